// File: rtl/bridge_reg_responder_if.sv
// Bridge bus port bundle between the initiator tree and a leaf register responder.
interface bridge_reg_responder_if;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        bridge_wr;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;

    modport master (
        output bridge_addr, bridge_wr_data, bridge_wr, bridge_rd,
        input  bridge_rd_data
    );
    modport slave (
        input  bridge_addr, bridge_wr_data, bridge_wr, bridge_rd,
        output bridge_rd_data
    );
endinterface

// File: rtl/bridge_reg_responder.sv
// Leaf register responder on the bridge bus: W1C status, doorbell command with
// valid/ack to the core, and a bank of plain read/write control registers.
module bridge_reg_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    bridge_reg_responder_if.slave           bus,
    output logic [NUM_REGS-3:0][31:0]       ctrl_regs,
    output logic [NUM_REGS-3:0]             ctrl_wr_strobe,
    input  logic [31:0]                     status_set,
    output logic [31:0]                     status,
    output logic                            cmd_valid,
    output logic [31:0]                     cmd_data,
    input  logic                            cmd_ack
);
    localparam int OW = $clog2(NUM_REGS);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [31:0]   cmd_data_nxt;
    logic          overrun, overrun_nxt;
    logic          hit, wr_hit, rd_hit, db_wr, db_rd, st_wr;
    logic [OW-1:0] off;
    logic [31:0]   rd_mux;
    logic          unused_addr_bits;

    assign hit    = (bus.bridge_addr[31:2+OW] == BASE_ADDR[31:2+OW]);
    assign off    = bus.bridge_addr[2 +: OW];
    assign wr_hit = bus.bridge_wr & hit;
    assign rd_hit = bus.bridge_rd & hit;
    assign st_wr  = wr_hit && (off == OW'(0));
    assign db_wr  = wr_hit && (off == OW'(1));
    assign db_rd  = rd_hit && (off == OW'(1));
    assign unused_addr_bits = ^bus.bridge_addr[1:0];

    assign cmd_valid = (state == PENDING);

    // Set requests are applied after the W1C clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) status <= '0;
        else          status <= (status & ~(st_wr ? bus.bridge_wr_data : 32'h0)) | status_set;
    end

    genvar k;
    generate
        for (k = 0; k < NUM_REGS-2; k++) begin : g_ctrl
            logic sel;
            assign sel = wr_hit && (off == OW'(k+2));
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ctrl_regs[k]      <= CTRL_RESET;
                    ctrl_wr_strobe[k] <= 1'b0;
                end else begin
                    ctrl_wr_strobe[k] <= sel;
                    if (sel) ctrl_regs[k] <= bus.bridge_wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmd_data <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_data <= cmd_data_nxt;
            overrun  <= overrun_nxt;
        end
    end

    // A read clears overrun, but a write-while-pending in the same cycle re-flags it.
    always_comb begin
        state_nxt    = state;
        cmd_data_nxt = cmd_data;
        overrun_nxt  = overrun;
        if (db_rd) overrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (db_wr) begin
                    state_nxt    = PENDING;
                    cmd_data_nxt = bus.bridge_wr_data;
                end
            end
            PENDING: begin
                if (db_wr && cmd_ack)  cmd_data_nxt = bus.bridge_wr_data;
                else if (db_wr)        overrun_nxt  = 1'b1;
                else if (cmd_ack)      state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (off == OW'(0))      rd_mux = status;
        else if (off == OW'(1)) rd_mux = {30'b0, overrun, cmd_valid};
        else begin
            for (int i = 0; i < NUM_REGS-2; i++)
                if (off == OW'(i+2)) rd_mux = ctrl_regs[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    bus.bridge_rd_data <= '0;
        else if (rd_hit) bus.bridge_rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_bridge_reg_responder.sv
// Directed bench for bridge_reg_responder with hand-computed expectations.
module tb_bridge_reg_responder;
    logic              clk = 1'b0;
    logic              reset_n;
    logic [5:0][31:0]  ctrl_regs;
    logic [5:0]        ctrl_wr_strobe;
    logic [31:0]       status_set;
    logic [31:0]       status;
    logic              cmd_valid;
    logic [31:0]       cmd_data;
    logic              cmd_ack;
    int                errors = 0;
    int                checks = 0;

    bridge_reg_responder_if bus();

    bridge_reg_responder #(
        .BASE_ADDR(32'h8000_0000), .NUM_REGS(8), .CTRL_RESET(32'h0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .ctrl_regs(ctrl_regs), .ctrl_wr_strobe(ctrl_wr_strobe),
        .status_set(status_set), .status(status),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ack(cmd_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.bridge_addr = a; bus.bridge_wr_data = d; bus.bridge_wr = 1'b1;
        step();
        bus.bridge_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.bridge_addr = a; bus.bridge_rd = 1'b1;
        step();
        bus.bridge_rd = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; bus.bridge_addr = '0; bus.bridge_wr_data = '0;
        bus.bridge_wr = 1'b0; bus.bridge_rd = 1'b0;
        status_set = '0; cmd_ack = 1'b0;
        #12;
        chk("rst_rd_data", bus.bridge_rd_data, 0);
        chk("rst_status", status, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_ctrl", ctrl_regs, 0);
        chk("rst_strobe", ctrl_wr_strobe, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            rd(32'h8000_0000 + 32'(i*4));
            chk($sformatf("rd_reset_off%0d", i), bus.bridge_rd_data, 0);
        end

        // control register write, strobe, readback, window miss
        wr(32'h8000_0008, 32'hDEAD_BEEF);
        chk("ctrl2_val", ctrl_regs[0], 32'hDEAD_BEEF);
        chk("ctrl2_strobe", ctrl_wr_strobe, 6'b000001);
        step();
        chk("strobe_one_cycle", ctrl_wr_strobe, 0);
        rd(32'h8000_0008);
        chk("ctrl2_readback", bus.bridge_rd_data, 32'hDEAD_BEEF);
        wr(32'h8000_0108, 32'h1234);
        chk("miss_no_change", ctrl_regs, {160'h0, 32'hDEAD_BEEF});
        chk("miss_no_strobe", ctrl_wr_strobe, 0);
        rd(32'h8000_0108);
        chk("miss_rd_holds", bus.bridge_rd_data, 32'hDEAD_BEEF);
        wr(32'h8000_001C, 32'hCAFE);
        chk("ctrl7_strobe", ctrl_wr_strobe, 6'b100000);
        chk("ctrl7_val", ctrl_regs[5], 32'hCAFE);
        rd(32'h8000_001F);
        chk("addr_lsb_ignored", bus.bridge_rd_data, 32'hCAFE);

        // status set / W1C / set wins
        status_set = 32'h5; step(); status_set = '0;
        chk("status_set", status, 32'h5);
        wr(32'h8000_0000, 32'h1);
        chk("status_w1c", status, 32'h4);
        status_set = 32'h4; wr(32'h8000_0000, 32'h4); status_set = '0;
        chk("status_set_wins", status, 32'h4);
        wr(32'h8000_0000, 32'h4);
        chk("status_w1c_all", status, 32'h0);
        rd(32'h8000_0000);
        chk("status_rd", bus.bridge_rd_data, 32'h0);

        // doorbell handshake and overrun
        wr(32'h8000_0004, 32'hA5);
        chk("db_valid", cmd_valid, 1);
        chk("db_data", cmd_data, 32'hA5);
        wr(32'h8000_0004, 32'h5A);
        chk("db_overrun_drop", cmd_data, 32'hA5);
        rd(32'h8000_0004);
        chk("db_rd_overrun", bus.bridge_rd_data, 32'h3);
        rd(32'h8000_0004);
        chk("db_rd_cleared", bus.bridge_rd_data, 32'h1);
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        chk("db_ack_idle", cmd_valid, 0);
        chk("db_ack_data_holds", cmd_data, 32'hA5);
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        chk("db_ack_in_idle", cmd_valid, 0);

        wr(32'h8000_0004, 32'h11);
        cmd_ack = 1'b1; wr(32'h8000_0004, 32'h77); cmd_ack = 1'b0;
        chk("db_ackwr_valid", cmd_valid, 1);
        chk("db_ackwr_data", cmd_data, 32'h77);
        rd(32'h8000_0004);
        chk("db_ackwr_no_overrun", bus.bridge_rd_data, 32'h1);

        // same-cycle write and read
        wr(32'h8000_0008, 32'h9);
        bus.bridge_rd = 1'b1; wr(32'h8000_0008, 32'h1); bus.bridge_rd = 1'b0;
        chk("wr_rd_old_data", bus.bridge_rd_data, 32'h9);
        chk("wr_rd_new_reg", ctrl_regs[0], 32'h1);

        // async reset mid-access
        bus.bridge_addr = 32'h8000_000C; bus.bridge_wr_data = 32'h55;
        bus.bridge_wr = 1'b1; bus.bridge_rd = 1'b1; status_set = 32'h3;
        @(negedge clk);
        reset_n = 1'b0; #1;
        chk("arst_rd_data", bus.bridge_rd_data, 0);
        chk("arst_status", status, 0);
        chk("arst_ctrl", ctrl_regs, 0);
        chk("arst_strobe", ctrl_wr_strobe, 0);
        chk("arst_cmd_valid", cmd_valid, 0);
        chk("arst_cmd_data", cmd_data, 0);
        bus.bridge_wr = 1'b0; bus.bridge_rd = 1'b0; status_set = '0;
        reset_n = 1'b1;
        step();
        rd(32'h8000_0004);
        chk("arst_overrun_clear", bus.bridge_rd_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
